i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- I2C slave (target) that answers the bus master on the level board. It lets master-side transactions be checked in simulation and on a second FPGA, acting as an accelerometer-style register device.
- Holds a small register file. The master sets a register pointer and then writes or reads bytes with auto-increment.
- A local port lets the surrounding logic (for example a sensor model) update registers. Bus writes are reported back to that logic.
- SCL is input-only; the block never stretches the clock.

Parameters:
- SLAVE_ADDR, 7'h1D: 7-bit device address the block acknowledges.
- REG_AW, 4: register pointer width; the register file has 2**REG_AW bytes.
- RESET_VAL, 8'h00: reset value of every register.

Ports:
- clk  in  1  system clock; must be at least 16x the SCL frequency.
- reset_i  in  1  asynchronous, active-low reset.
- scl_i  in  1  SCL line level.
- sda_i  in  1  SDA line level.
- sda_o  out  1  SDA drive value; constant 0 (open-drain).
- sda_oe  out  1  1 = pull SDA low.
- loc_wr_i  in  1  local register write strobe.
- loc_addr_i  in  REG_AW  local write address.
- loc_data_i  in  8  local write data.
- bus_wr_o  out  1  one-clk pulse per byte the master writes to a register.
- bus_addr_o  out  REG_AW  register address of that write.
- bus_data_o  out  8  data of that write.
- busy_o  out  1  high from address match until STOP, NACK or mismatch.

Behaviour:
- Reset values:
  - sda_oe=0, sda_o=0, bus_wr_o=0, bus_addr_o=0, bus_data_o=0, busy_o=0.
  - Pointer=0, all registers=RESET_VAL, state IDLE.
  - Synchronizers reset to 1.
- Input sampling:
  - scl_i and sda_i each pass through a 2-flop synchronizer, then a previous-value register for edge detection.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
  - Data bits are sampled on the detected SCL rising edge.
  - sda_oe changes only on the detected SCL falling edge.
  - Latency from a pin edge to the internal event is 3 clk.
- States:
  - IDLE: ignore everything except START.
  - ADDR: shift in 8 bits, MSB first.
    - Bits[7:1]==SLAVE_ADDR: go to ACK_ADDR and set busy_o.
    - Otherwise: go to IDLE with no ACK.
  - ACK_ADDR: drive sda_oe=1 for one SCL low/high period.
    - R/W=0: go to RX_PTR.
    - R/W=1: load the TX shift register with reg[ptr], then go to TX.
  - RX_PTR: shift in 8 bits. ptr takes the low REG_AW bits; upper bits are ignored. ACK, then go to RX_DATA.
  - RX_DATA: shift in 8 bits.
    - At the 8th SCL rise: reg[ptr] = byte, bus_wr_o pulses for 1 clk with the pre-increment address, then ptr increments.
    - ACK, then stay in RX_DATA.
  - TX: drive sda_oe = ~bit on each SCL fall, MSB first. After 8 bits release SDA and go to RX_ACK.
  - RX_ACK: sample SDA on SCL rise.
    - Sample 0 (master ACK): ptr increments, reload from reg[ptr], go to TX.
    - Sample 1 (master NACK): release SDA, clear busy_o, go to IDLE.
- Pointer arithmetic: modulo 2**REG_AW; wraps 2**REG_AW-1 -> 0 in both directions of transfer.
- Read data is captured into the shift register at load time. A local write during the byte does not alter bits already being sent.
- Simultaneous local and bus write:
  - Same address: the bus write wins.
  - Different addresses: both take effect.
- START in any state (repeated START): abort the current byte, release sda_oe, go to ADDR. ptr is preserved.
- STOP in any state: release sda_oe, clear busy_o, go to IDLE. A partial byte is discarded; no register write, no bus_wr_o.
- A General call (address 0) is not acknowledged.
- Reset asserted mid-transfer: outputs return to reset values immediately (asynchronous). The block waits for the next START.

Test Plan:
1. Write: START, 0x3A(W), 0x05, 0xA1, 0xB2, STOP -> ACK after every byte. bus_wr_o pulses twice, (5,0xA1) then (6,0xB2). reg5=0xA1, reg6=0xB2. Final ptr=7.
2. Combined read: START 0x3A, 0x05, repeated START 0x3B; master ACKs, then NACKs -> SDA bytes 0xA1 then 0xB2. SDA released after the NACK. busy_o falls.
3. Wrong address: START 0x40 -> no ACK (SDA stays high on the 9th clock), busy_o=0, no bus_wr_o. The next START 0x3A is still acknowledged.
4. Wrap: local writes reg15=0x5A and reg0=0xC3; set ptr=0x0F, read 2 bytes -> 0x5A, 0xC3.
5. Abort: STOP after 4 data bits of a write to reg2 -> reg2 unchanged, no bus_wr_o, state IDLE.
6. Collision: local write reg6=0x11 in the same clk as bus write reg6=0x22 -> reg6=0x22. Then drive reset_i low mid-read -> sda_oe=0 and busy_o=0 in the same cycle.

Source files
------------

// File: rtl/i2c_target.sv
// ---------------------------------------------------------------------------
// i2c_target
//
// I2C target (slave) modelling a small accelerometer-style register device.
// The master writes a register pointer, then writes or reads bytes. The
// pointer auto-increments and wraps modulo 2**REG_AW. SCL is input-only, so
// the clock is never stretched. SDA is open-drain: sda_o is tied low and
// sda_oe selects between pulling the line low and releasing it.
//
// Ports
//   clk         system clock, at least 16x the SCL frequency
//   reset_i     asynchronous active-low reset
//   scl_i       SCL line level
//   sda_i       SDA line level
//   sda_o       SDA drive value, constant 0
//   sda_oe      1 = pull SDA low
//   loc_wr_i    local register write strobe
//   loc_addr_i  local write address
//   loc_data_i  local write data
//   bus_wr_o    one-clk pulse per data byte written by the master
//   bus_addr_o  register address of that write
//   bus_data_o  data of that write
//   busy_o      high from address match until STOP, NACK or mismatch
// ---------------------------------------------------------------------------
module i2c_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'h1D,
    parameter int         REG_AW     = 4,
    parameter logic [7:0] RESET_VAL  = 8'h00
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_o,
    output logic              sda_oe,
    input  logic              loc_wr_i,
    input  logic [REG_AW-1:0] loc_addr_i,
    input  logic [7:0]        loc_data_i,
    output logic              bus_wr_o,
    output logic [REG_AW-1:0] bus_addr_o,
    output logic [7:0]        bus_data_o,
    output logic              busy_o
);

    localparam int NREGS = 1 << REG_AW;
    localparam logic [REG_AW-1:0] PTR_ONE = 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ACK_ADDR = 3'd2;
    localparam logic [2:0] ST_RX_PTR   = 3'd3;
    localparam logic [2:0] ST_RX_DATA  = 3'd4;
    localparam logic [2:0] ST_ACK_RX   = 3'd5;
    localparam logic [2:0] ST_TX       = 3'd6;
    localparam logic [2:0] ST_RX_ACK   = 3'd7;

    // ---------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ---------------------------------------------------------------------
    logic scl_s1, scl_s2, scl_q;
    logic sda_s1, sda_s2, sda_q;

    // Reset to 1 so an idle (pulled-up) bus produces no edges after reset.
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of the others, like real hardware.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_q  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_q  <= 1'b1;
        end else begin
            scl_s1 <= scl_i;
            scl_s2 <= scl_s1;
            scl_q  <= scl_s2;
            sda_s1 <= sda_i;
            sda_s2 <= sda_s1;
            sda_q  <= sda_s2;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise  = scl_s2 & ~scl_q;
    assign scl_fall  = ~scl_s2 & scl_q;
    // SDA may only change while SCL is low; a change with SCL held high on
    // both samples is a bus condition, not data.
    assign start_det = scl_s2 & scl_q & sda_q & ~sda_s2;
    assign stop_det  = scl_s2 & scl_q & ~sda_q & sda_s2;

    // ---------------------------------------------------------------------
    // Protocol state
    // ---------------------------------------------------------------------
    logic [2:0]        state;
    logic [3:0]        bit_cnt;
    logic [6:0]        shift_in;
    logic [7:0]        tx_sh;
    logic [REG_AW-1:0] ptr;
    logic              rw;
    logic              ack_on;

    logic [7:0]        regs [NREGS];
    logic [7:0]        in_byte;
    logic [7:0]        rd_byte;
    logic [7:0]        next_rd_byte;
    logic              bus_we;
    logic              last_bit;

    // Byte as it will look once the bit on the current SCL rise is included.
    assign in_byte      = {shift_in, sda_s2};
    assign rd_byte      = regs[ptr];
    assign next_rd_byte = regs[ptr + PTR_ONE];
    assign last_bit     = (bit_cnt == 4'd7);
    assign bus_we       = (state == ST_RX_DATA) && scl_rise && last_bit;

    assign sda_o = 1'b0;

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state      <= ST_IDLE;
            bit_cnt    <= 4'd0;
            shift_in   <= 7'd0;
            tx_sh      <= 8'd0;
            ptr        <= '0;
            rw         <= 1'b0;
            ack_on     <= 1'b0;
            sda_oe     <= 1'b0;
            busy_o     <= 1'b0;
            bus_wr_o   <= 1'b0;
            bus_addr_o <= '0;
            bus_data_o <= 8'd0;
        end else begin
            bus_wr_o <= 1'b0;

            if (start_det) begin
                // Repeated START aborts the byte in flight; ptr is kept so
                // a combined write-pointer/read sequence works.
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
                ack_on  <= 1'b0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state  <= ST_IDLE;
                ack_on <= 1'b0;
                sda_oe <= 1'b0;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // Only a START leaves IDLE.
                    end

                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_in <= in_byte[6:0];
                            if (last_bit) begin
                                // General call (address 0) is never acknowledged.
                                if (in_byte[7:1] == SLAVE_ADDR && in_byte[7:1] != 7'd0) begin
                                    state  <= ST_ACK_ADDR;
                                    rw     <= in_byte[0];
                                    ack_on <= 1'b0;
                                    busy_o <= 1'b1;
                                end else begin
                                    state  <= ST_IDLE;
                                    busy_o <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    ST_ACK_ADDR: begin
                        // First fall: pull SDA for the ACK slot.
                        // Second fall: end of the ACK slot.
                        if (scl_fall) begin
                            if (!ack_on) begin
                                sda_oe <= 1'b1;
                                ack_on <= 1'b1;
                            end else begin
                                ack_on <= 1'b0;
                                if (rw) begin
                                    // The ACK slot ends on the same fall the
                                    // first data bit must appear, so MSB is
                                    // driven straight from the loaded byte.
                                    tx_sh   <= {rd_byte[6:0], 1'b0};
                                    sda_oe  <= ~rd_byte[7];
                                    bit_cnt <= 4'd1;
                                    state   <= ST_TX;
                                end else begin
                                    sda_oe  <= 1'b0;
                                    bit_cnt <= 4'd0;
                                    state   <= ST_RX_PTR;
                                end
                            end
                        end
                    end

                    ST_RX_PTR: begin
                        if (scl_rise) begin
                            shift_in <= in_byte[6:0];
                            if (last_bit) begin
                                ptr    <= in_byte[REG_AW-1:0];
                                ack_on <= 1'b0;
                                state  <= ST_ACK_RX;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    ST_RX_DATA: begin
                        if (scl_rise) begin
                            shift_in <= in_byte[6:0];
                            if (last_bit) begin
                                bus_wr_o   <= 1'b1;
                                bus_addr_o <= ptr;
                                bus_data_o <= in_byte;
                                ptr        <= ptr + PTR_ONE;
                                ack_on     <= 1'b0;
                                state      <= ST_ACK_RX;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    ST_ACK_RX: begin
                        if (scl_fall) begin
                            if (!ack_on) begin
                                sda_oe <= 1'b1;
                                ack_on <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                ack_on  <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= ST_RX_DATA;
                            end
                        end
                    end

                    ST_TX: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= ST_RX_ACK;
                            end else begin
                                sda_oe  <= ~tx_sh[7];
                                tx_sh   <= {tx_sh[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    ST_RX_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s2) begin
                                // Master ACK: capture the next byte now so a
                                // later local write cannot disturb it.
                                ptr     <= ptr + PTR_ONE;
                                tx_sh   <= next_rd_byte;
                                bit_cnt <= 4'd0;
                                state   <= ST_TX;
                            end else begin
                                busy_o <= 1'b0;
                                state  <= ST_IDLE;
                            end
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // Register file
    // ---------------------------------------------------------------------
    // NOTE: the register file is reset because the device must read back
    // RESET_VAL after reset; memories without that need are left unreset.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            if (loc_wr_i) begin
                regs[loc_addr_i] <= loc_data_i;
            end
            // Placed after the local write so it wins on an address clash.
            if (bus_we) begin
                regs[ptr] <= in_byte;
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_target
//
// Bit-banged I2C master driving i2c_target, with a transaction-level model
// (register array, pointer, queue of expected bus writes). A compare process
// on every falling clk edge checks bus_wr_o pulses and sda_o against the model.
// ---------------------------------------------------------------------------
module tb_i2c_target;

    localparam int Q = 5;  // quarter SCL period in clk cycles (SCL = clk/20)

    logic       clk = 1'b0;
    logic       reset_i;
    logic       scl_m;
    logic       sda_m;
    logic       sda_line;
    logic       sda_o;
    logic       sda_oe;
    logic       loc_wr_i;
    logic [3:0] loc_addr_i;
    logic [7:0] loc_data_i;
    logic       bus_wr_o;
    logic [3:0] bus_addr_o;
    logic [7:0] bus_data_o;
    logic       busy_o;

    always #5 clk = ~clk;

    // Open-drain wired-AND of master and target.
    assign sda_line = sda_m & ~sda_oe;

    i2c_target dut (
        .clk        (clk),
        .reset_i    (reset_i),
        .scl_i      (scl_m),
        .sda_i      (sda_line),
        .sda_o      (sda_o),
        .sda_oe     (sda_oe),
        .loc_wr_i   (loc_wr_i),
        .loc_addr_i (loc_addr_i),
        .loc_data_i (loc_data_i),
        .bus_wr_o   (bus_wr_o),
        .bus_addr_o (bus_addr_o),
        .bus_data_o (bus_data_o),
        .busy_o     (busy_o)
    );

    // ------------------------------------------------------------------
    // Model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic [7:0] m_regs [16];
    logic [3:0] m_ptr;
    wr_t        exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr = 4'd0;
        exp_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------
    logic prev_wr = 1'b0;
    wr_t  e;

    always @(negedge clk) begin
        check("sda_o constant", sda_o, 1'b0);
        if (prev_wr) check("bus_wr pulse width", bus_wr_o, 1'b0);
        if (bus_wr_o && !prev_wr) begin
            if (exp_q.size() == 0) begin
                check("bus_wr unexpected", bus_wr_o, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("bus_addr", bus_addr_o, e.a);
                check("bus_data", bus_data_o, e.d);
            end
        end
        prev_wr = bus_wr_o;
    end

    // ------------------------------------------------------------------
    // Bit-level master
    // ------------------------------------------------------------------
    task automatic wq(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq(Q);
        scl_m = 1'b1; wq(Q);
        sda_m = 1'b0; wq(Q);
        scl_m = 1'b0; wq(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq(Q);
        scl_m = 1'b1; wq(Q);
        sda_m = 1'b1; wq(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wq(Q);
        scl_m = 1'b1; wq(2 * Q);
        scl_m = 1'b0; wq(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wq(Q);
        scl_m = 1'b1; wq(Q);
        b = sda_line; wq(Q);
        scl_m = 1'b0; wq(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(a);
        ack = ~a;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic mack);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(v);
            b[i] = v;
        end
        send_bit(~mack);
    endtask

    task automatic local_write(input logic [3:0] a, input logic [7:0] d);
        loc_addr_i = a;
        loc_data_i = d;
        loc_wr_i   = 1'b1;
        wq(1);
        loc_wr_i   = 1'b0;
        m_regs[a]  = d;
    endtask

    // ------------------------------------------------------------------
    // Transactions
    // ------------------------------------------------------------------
    task automatic tr_write(input logic [3:0] p, input int n, input logic [31:0] data);
        logic       ack;
        logic [3:0] hi;
        logic [7:0] d;
        hi = 4'($urandom);
        i2c_start();
        write_byte({7'h1D, 1'b0}, ack);
        check("write addr ack", ack, 1'b1);
        check("busy after match", busy_o, 1'b1);
        write_byte({hi, p}, ack);
        check("ptr ack", ack, 1'b1);
        m_ptr = p;
        for (int i = 0; i < n; i++) begin
            d = data[8*i +: 8];
            exp_q.push_back('{a: m_ptr, d: d});
            m_regs[m_ptr] = d;
            m_ptr = m_ptr + 4'd1;
            write_byte(d, ack);
            check("data ack", ack, 1'b1);
        end
        i2c_stop();
        wq(4);
        check("busy after stop", busy_o, 1'b0);
    endtask

    task automatic tr_read(input logic set_ptr, input logic [3:0] p, input int n,
                           output logic [31:0] got);
        logic       ack;
        logic [7:0] b;
        logic [7:0] exp;
        got = '0;
        i2c_start();
        if (set_ptr) begin
            write_byte({7'h1D, 1'b0}, ack);
            check("read setup addr ack", ack, 1'b1);
            write_byte({4'h0, p}, ack);
            check("read setup ptr ack", ack, 1'b1);
            m_ptr = p;
            i2c_start();
        end
        write_byte({7'h1D, 1'b1}, ack);
        check("read addr ack", ack, 1'b1);
        check("busy in read", busy_o, 1'b1);
        for (int i = 0; i < n; i++) begin
            exp = m_regs[m_ptr];
            read_byte(b, i < n - 1);
            check("read data", b, exp);
            got[8*i +: 8] = b;
            if (i < n - 1) m_ptr = m_ptr + 4'd1;
        end
        wq(2);
        check("sda released after nack", sda_oe, 1'b0);
        check("busy after nack", busy_o, 1'b0);
        i2c_stop();
    endtask

    task automatic tr_bad(input logic [6:0] a, input logic r);
        logic ack;
        i2c_start();
        write_byte({a, r}, ack);
        check("bad addr no ack", ack, 1'b0);
        check("bad addr busy", busy_o, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] got;
        logic        ack;
        logic [6:0]  ba;
        logic [7:0]  cb;

        reset_i    = 1'b0;
        scl_m      = 1'b1;
        sda_m      = 1'b1;
        loc_wr_i   = 1'b0;
        loc_addr_i = 4'd0;
        loc_data_i = 8'd0;
        model_reset();
        wq(3);
        check("reset sda_oe", sda_oe, 1'b0);
        check("reset busy", busy_o, 1'b0);
        check("reset bus_wr", bus_wr_o, 1'b0);
        check("reset bus_addr", bus_addr_o, 4'd0);
        check("reset bus_data", bus_data_o, 8'd0);
        reset_i = 1'b1;
        wq(3);

        // 1: write two bytes from pointer 5
        tr_write(4'd5, 2, 32'h0000_B2A1);
        local_write(4'd7, 8'h77);
        tr_read(1'b0, 4'd0, 1, got);          // current address must be 7
        check("lit final ptr 7", got[7:0], 8'h77);

        // 2: combined write-pointer / repeated-START read
        tr_read(1'b1, 4'd5, 2, got);
        check("lit read reg5", got[7:0], 8'hA1);
        check("lit read reg6", got[15:8], 8'hB2);

        // 3: wrong address, general call, then a normal access
        tr_bad(7'h20, 1'b0);
        tr_write(4'd3, 1, 32'h0000_003C);
        tr_bad(7'h00, 1'b0);
        i2c_stop();

        // 4: pointer wrap on read
        local_write(4'd15, 8'h5A);
        local_write(4'd0, 8'hC3);
        tr_read(1'b1, 4'd15, 2, got);
        check("lit wrap reg15", got[7:0], 8'h5A);
        check("lit wrap reg0", got[15:8], 8'hC3);

        // 5: STOP after 4 data bits
        i2c_start();
        write_byte({7'h1D, 1'b0}, ack);
        check("abort addr ack", ack, 1'b1);
        write_byte(8'h02, ack);
        check("abort ptr ack", ack, 1'b1);
        m_ptr = 4'd2;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i2c_stop();
        wq(4);
        check("abort busy", busy_o, 1'b0);
        scl_m = 1'b0; wq(Q);
        write_byte({7'h1D, 1'b0}, ack);       // no START: must be ignored
        check("idle after abort", ack, 1'b0);
        tr_read(1'b1, 4'd2, 1, got);
        check("lit reg2 unchanged", got[7:0], 8'h00);

        // Randomized traffic
        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 3))
                0: tr_write(4'($urandom), int'($urandom_range(1, 4)), $urandom);
                1: tr_read(1'($urandom), 4'($urandom), int'($urandom_range(1, 4)), got);
                2: begin
                    for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                        local_write(4'($urandom), 8'($urandom));
                end
                default: begin
                    do ba = 7'($urandom); while (ba == 7'h1D);
                    tr_bad(ba, 1'($urandom));
                    i2c_stop();
                end
            endcase
        end

        // 6a: local and bus write to reg6 in the same clk; bus wins
        i2c_start();
        write_byte({7'h1D, 1'b0}, ack);
        check("coll addr ack", ack, 1'b1);
        write_byte(8'h06, ack);
        check("coll ptr ack", ack, 1'b1);
        cb = 8'h22;
        for (int i = 7; i >= 1; i--) send_bit(cb[i]);
        exp_q.push_back('{a: 4'd6, d: 8'h22});
        m_regs[6] = 8'h22;
        m_ptr = 4'd7;
        sda_m = cb[0]; wq(Q);
        scl_m = 1'b1;                          // bus write lands 3 clk later
        @(posedge clk); #1;
        loc_addr_i = 4'd6;
        loc_data_i = 8'h11;
        loc_wr_i   = 1'b1;                     // covers the 2nd and 3rd edges
        @(posedge clk);
        @(posedge clk); #1;
        loc_wr_i   = 1'b0;
        wq(2 * Q - 3);
        scl_m = 1'b0; wq(Q);
        recv_bit(ack);
        check("coll data ack", ack, 1'b0);     // raw SDA level: 0 = ACK
        i2c_stop();
        tr_read(1'b1, 4'd6, 1, got);
        check("lit collision reg6", got[7:0], 8'h22);

        // 6b: reset during a read
        i2c_start();
        write_byte({7'h1D, 1'b0}, ack);
        write_byte(8'h06, ack);
        i2c_start();
        write_byte({7'h1D, 1'b1}, ack);
        check("pre-reset read ack", ack, 1'b1);
        check("pre-reset tx drive", sda_oe, 1'b1);   // MSB of 0x22 is 0
        reset_i = 1'b0;
        #2;
        check("async reset sda_oe", sda_oe, 1'b0);
        check("async reset busy", busy_o, 1'b0);
        model_reset();
        wq(2);
        reset_i = 1'b1;
        wq(2);
        tr_read(1'b1, 4'd6, 1, got);
        check("lit reg6 after reset", got[7:0], 8'h00);

        wq(10);
        check("bus writes drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
